// File: rtl/vga_console_pkg.sv
// Shared types and constants for the VGA text console: screen geometry,
// bus base addresses, control codes and FSM/cursor encodings.
package vga_console_pkg;

    localparam int COLS          = 80;
    localparam int ROWS          = 30;
    localparam int WORDS_PER_ROW = COLS / 4;
    localparam int WORDS_ALL     = ROWS * COLS / 4;

    localparam logic [31:0] CHAR_BASE  = 32'h0000_0000;
    localparam logic [31:0] COL_BASE   = 32'h0000_1000;
    localparam logic [31:0] SPACE_WORD = 32'h2020_2020;

    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] BS = 8'h08;
    localparam logic [7:0] FF = 8'h0C;

    typedef enum logic [2:0] {
        IDLE,
        WR_CHAR,
        WR_COL,
        CLR_ROW,
        CLR_ALL
    } state_e;

    // Cursor update requested by the console FSM for the coming edge.
    typedef enum logic [2:0] {
        CUR_HOLD,
        CUR_INC,
        CUR_NEWLINE,
        CUR_CR,
        CUR_BS,
        CUR_HOME
    } cur_op_e;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/vga_text_console_if.sv
// Write-only system-bus interface between the text console (master) and the
// VGA peripheral's bus controller (slave).
interface vga_text_console_if;

    logic        req_o;
    logic        write_enable_o;
    logic [3:0]  mem_be_o;
    logic [31:0] addr_o;
    logic [31:0] write_data_o;

    modport master (
        output req_o,
        output write_enable_o,
        output mem_be_o,
        output addr_o,
        output write_data_o
    );

    modport slave (
        input req_o,
        input write_enable_o,
        input mem_be_o,
        input addr_o,
        input write_data_o
    );

endinterface

// File: rtl/vga_cursor.sv
// Row/column cursor of the 80x30 text console: advance, newline, carriage
// return, backspace and home, plus the linear screen index of the cursor.
module vga_cursor
    import vga_console_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  cur_op_e     op_i,
    output logic [4:0]  row_o,
    output logic [6:0]  col_o,
    output logic [11:0] row_base_o,
    output logic [11:0] idx_o,
    output logic        col_last_o,
    output logic        col_zero_o
);

    logic [4:0] row_q, row_d;
    logic [6:0] col_q, col_d;
    logic [4:0] row_next;

    assign col_last_o = (col_q == 7'(COLS - 1));
    assign col_zero_o = (col_q == 7'd0);
    // Moving past the last row wraps to the top; there is no scrolling.
    assign row_next   = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;

    // 12 bits hold the largest index (29*80+79 = 2399).
    assign row_base_o = 12'(row_q) * 12'(COLS);
    assign idx_o      = row_base_o + 12'(col_q);

    assign row_o = row_q;
    assign col_o = col_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        row_d = row_q;
        col_d = col_q;
        unique case (op_i)
            CUR_INC: begin
                if (col_last_o) begin
                    col_d = 7'd0;
                    row_d = row_next;
                end else begin
                    col_d = col_q + 7'd1;
                end
            end
            CUR_NEWLINE: begin
                col_d = 7'd0;
                row_d = row_next;
            end
            CUR_CR: col_d = 7'd0;
            CUR_BS: begin
                if (!col_zero_o) col_d = col_q - 7'd1;
            end
            CUR_HOME: begin
                row_d = 5'd0;
                col_d = 7'd0;
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            row_q <= 5'd0;
            col_q <= 7'd0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/vga_text_console.sv
// Byte-stream to VGA bus writer: prints characters with attributes, handles
// LF/CR/BS/FF and clears rows or the whole screen with word writes.
module vga_text_console
    import vga_console_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [7:0]                data_i,
    input  logic [7:0]                color_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    vga_text_console_if.master        bus,
    output logic [4:0]                cursor_row_o,
    output logic [6:0]                cursor_col_o
);

    state_e      state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  color_q, color_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        bs_q, bs_d;

    cur_op_e     cur_op;
    logic [11:0] row_base;
    logic [11:0] idx;
    logic        col_last;
    logic        col_zero;

    logic        req;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        accept;

    vga_cursor u_cursor (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .op_i       (cur_op),
        .row_o      (cursor_row_o),
        .col_o      (cursor_col_o),
        .row_base_o (row_base),
        .idx_o      (idx),
        .col_last_o (col_last),
        .col_zero_o (col_zero)
    );

    assign ready_o = !rst_i && (state_q == IDLE);
    assign accept  = valid_i && ready_o;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        color_d = color_q;
        cnt_d   = cnt_q;
        bs_d    = bs_q;
        cur_op  = CUR_HOLD;
        req     = 1'b0;
        be      = 4'b0000;
        addr    = 32'h0;
        wdata   = 32'h0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = data_i;
                    color_d = color_i;
                    bs_d    = 1'b0;
                    cnt_d   = 10'd0;
                    if (is_printable(data_i)) begin
                        state_d = WR_CHAR;
                    end else begin
                        unique case (data_i)
                            LF: begin
                                cur_op  = CUR_NEWLINE;
                                state_d = CLR_ROW;
                            end
                            CR: cur_op = CUR_CR;
                            BS: begin
                                // Erase the cell left of the cursor; attributes stay.
                                if (!col_zero) begin
                                    cur_op  = CUR_BS;
                                    data_d  = 8'h20;
                                    bs_d    = 1'b1;
                                    state_d = WR_CHAR;
                                end
                            end
                            FF:      state_d = CLR_ALL;
                            default: ;
                        endcase
                    end
                end
            end
            WR_CHAR: begin
                req     = 1'b1;
                be      = 4'b0001 << idx[1:0];
                addr    = CHAR_BASE + 32'(idx);
                wdata   = {4{data_q}};
                state_d = bs_q ? IDLE : WR_COL;
            end
            WR_COL: begin
                req     = 1'b1;
                be      = 4'b0001 << idx[1:0];
                addr    = COL_BASE + 32'(idx);
                wdata   = {4{color_q}};
                cur_op  = CUR_INC;
                // Wrapping onto a new line blanks it before the next byte.
                state_d = col_last ? CLR_ROW : IDLE;
            end
            CLR_ROW: begin
                req   = 1'b1;
                be    = 4'hF;
                addr  = CHAR_BASE + 32'(row_base + {cnt_q, 2'b00});
                wdata = SPACE_WORD;
                if (cnt_q == 10'(WORDS_PER_ROW - 1)) begin
                    cnt_d   = 10'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            CLR_ALL: begin
                req   = 1'b1;
                be    = 4'hF;
                addr  = CHAR_BASE + 32'({cnt_q, 2'b00});
                wdata = SPACE_WORD;
                if (cnt_q == 10'(WORDS_ALL - 1)) begin
                    cnt_d   = 10'd0;
                    cur_op  = CUR_HOME;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            data_q  <= 8'h00;
            color_q <= 8'h00;
            cnt_q   <= 10'd0;
            bs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            color_q <= color_d;
            cnt_q   <= cnt_d;
            bs_q    <= bs_d;
        end
    end

    assign bus.req_o          = req;
    assign bus.write_enable_o = req;
    assign bus.mem_be_o       = be;
    assign bus.addr_o         = addr;
    assign bus.write_data_o   = wdata;

endmodule

// File: tb/tb_vga_text_console.sv
// Directed bench for vga_text_console: printing, line wrap, LF/CR/BS/FF,
// screen clear with mid-clear reset, and discarded control bytes.
module tb_vga_text_console;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] data_i;
    logic [7:0] color_i;
    logic       valid_i;
    logic       ready_o;
    logic [4:0] cursor_row_o;
    logic [6:0] cursor_col_o;

    int n_cmp = 0;
    int n_bad = 0;

    vga_text_console_if bus ();

    vga_text_console dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .color_i      (color_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .bus          (bus),
        .cursor_row_o (cursor_row_o),
        .cursor_col_o (cursor_col_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_ready();
        int budget = 0;
        while (ready_o !== 1'b1 && budget < 2000) begin
            tick();
            budget++;
        end
        check("ready_wait", 32'(ready_o), 32'd1);
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] c);
        wait_ready();
        data_i  = d;
        color_i = c;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic chk_bus(input string tag, input logic r, input logic [31:0] a,
                           input logic [3:0] b, input logic [31:0] w);
        check({tag, "_req"}, 32'(bus.req_o), 32'(r));
        check({tag, "_we"}, 32'(bus.write_enable_o), 32'(r));
        check({tag, "_addr"}, bus.addr_o, a);
        check({tag, "_be"}, 32'(bus.mem_be_o), 32'(b));
        check({tag, "_wdata"}, bus.write_data_o, w);
    endtask

    task automatic chk_cur(input string tag, input int r, input int c);
        check({tag, "_row"}, 32'(cursor_row_o), 32'(r));
        check({tag, "_col"}, 32'(cursor_col_o), 32'(c));
    endtask

    // Checks the char/colour write pair that follows acceptance of a printable byte.
    task automatic chk_print(input logic [31:0] idx, input logic [7:0] d, input logic [7:0] c);
        logic [3:0] b;
        b = 4'b0001 << idx[1:0];
        chk_bus("print_char", 1'b1, idx, b, {4{d}});
        tick();
        chk_bus("print_color", 1'b1, 32'h1000 + idx, b, {4{c}});
        tick();
    endtask

    task automatic chk_clear(input string tag, input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            chk_bus(tag, 1'b1, base + 32'(k * 4), 4'hF, 32'h2020_2020);
            check({tag, "_ready"}, 32'(ready_o), 32'd0);
            tick();
        end
        check({tag, "_done_req"}, 32'(bus.req_o), 32'd0);
        check({tag, "_done_ready"}, 32'(ready_o), 32'd1);
    endtask

    initial begin
        rst_i   = 1'b1;
        data_i  = 8'h00;
        color_i = 8'h00;
        valid_i = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst_ready", 32'(ready_o), 32'd0);
        chk_bus("rst", 1'b0, 32'h0, 4'h0, 32'h0);
        chk_cur("rst", 0, 0);
        rst_i = 1'b0;
        tick();
        check("post_rst_ready", 32'(ready_o), 32'd1);

        // 'A' with attribute 0x1F at 0,0.
        send(8'h41, 8'h1F);
        check("a_ready_busy", 32'(ready_o), 32'd0);
        chk_print(32'h0, 8'h41, 8'h1F);
        check("a_ready_back", 32'(ready_o), 32'd1);
        check("a_req_idle", 32'(bus.req_o), 32'd0);
        chk_cur("a", 0, 1);

        // CR from col 1 returns to col 0 with no bus cycle.
        send(8'h0D, 8'h00);
        check("cr_req", 32'(bus.req_o), 32'd0);
        check("cr_ready", 32'(ready_o), 32'd1);
        chk_cur("cr", 0, 0);

        // Full row of 80 characters, then the wrap clears row 1.
        for (int i = 0; i < 80; i++) begin
            logic [7:0] ch;
            ch = 8'h30 + 8'(i % 10);
            send(ch, 8'h07);
            chk_print(32'(i), ch, 8'h07);
        end
        chk_clear("wrap_clr", 32'h50, 20);
        chk_cur("wrap", 1, 0);

        // Walk to row 29, col 5.
        for (int i = 0; i < 28; i++) send(8'h0A, 8'h00);
        for (int i = 0; i < 5; i++) send(8'h61, 8'h02);
        wait_ready();
        chk_cur("pre_lf", 29, 5);

        // LF on the last row wraps to row 0 and clears it.
        send(8'h0A, 8'h00);
        chk_cur("lf_during", 0, 0);
        chk_clear("lf_clr", 32'h0, 20);
        chk_cur("lf", 0, 0);

        send(8'h0D, 8'h00);
        check("cr0_req", 32'(bus.req_o), 32'd0);
        chk_cur("cr0", 0, 0);

        // Backspace from col 3 blanks index 2 only.
        for (int i = 0; i < 3; i++) send(8'h62, 8'h03);
        wait_ready();
        chk_cur("pre_bs", 0, 3);
        send(8'h08, 8'h55);
        chk_bus("bs", 1'b1, 32'h2, 4'b0100, 32'h2020_2020);
        chk_cur("bs", 0, 2);
        tick();
        check("bs_req_after", 32'(bus.req_o), 32'd0);
        check("bs_ready_after", 32'(ready_o), 32'd1);

        // Backspace at col 0 does nothing.
        send(8'h0D, 8'h00);
        send(8'h08, 8'h00);
        check("bs0_req", 32'(bus.req_o), 32'd0);
        chk_cur("bs0", 0, 0);

        // Form feed: 600 word writes, cursor homed afterwards.
        send(8'h5A, 8'h04);
        chk_print(32'h0, 8'h5A, 8'h04);
        send(8'h0C, 8'h00);
        chk_cur("ff_during", 0, 1);
        chk_clear("ff_clr", 32'h0, 600);
        check("ff_last_addr_gap", 32'(600 * 4 - 4), 32'h95C);
        chk_cur("ff", 0, 0);

        // Form feed abandoned by reset at write 300.
        send(8'h51, 8'h05);
        chk_print(32'h0, 8'h51, 8'h05);
        send(8'h0C, 8'h00);
        for (int k = 0; k < 300; k++) begin
            check("ffr_addr", bus.addr_o, 32'(k * 4));
            tick();
        end
        chk_bus("ffr_300", 1'b1, 32'h4B0, 4'hF, 32'h2020_2020);
        rst_i = 1'b1;
        tick();
        chk_bus("ffr_rst", 1'b0, 32'h0, 4'h0, 32'h0);
        check("ffr_rst_ready", 32'(ready_o), 32'd0);
        chk_cur("ffr_rst", 0, 0);
        rst_i = 1'b0;
        tick();
        check("ffr_ready", 32'(ready_o), 32'd1);
        check("ffr_req", 32'(bus.req_o), 32'd0);

        // Unknown control byte with valid held: swallowed every cycle.
        send(8'h41, 8'h06);
        chk_print(32'h0, 8'h41, 8'h06);
        data_i  = 8'h07;
        valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bel_req", 32'(bus.req_o), 32'd0);
            check("bel_ready", 32'(ready_o), 32'd1);
            chk_cur("bel", 0, 1);
        end
        valid_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_text_console.md
Name: vga_text_console

Overview:
Bus master that turns a byte stream (UART receiver or debug port) into writes on the VGA peripheral's system-bus interface. It keeps an 80x30 text cursor and writes each printable byte to the character map and its attribute to the colour map. It handles control codes by moving the cursor, clearing a row, or clearing the whole screen. It sits directly upstream of the VGA system-bus controller and drives that controller's req/we/be/addr/wdata inputs. It issues writes only, one per cycle, and never waits on the bus.

Parameters:
COLS, 80, characters per row.
ROWS, 30, rows per screen.
CHAR_BASE, 32'h0000_0000, character-map byte base address.
COL_BASE, 32'h0000_1000, colour-map byte base address.

Ports:
clk_i  in  1  system clock; single clock domain.
rst_i  in  1  reset; synchronous, active-high.
data_i  in  8  input byte.
color_i  in  8  attribute byte; sampled together with data_i.
valid_i  in  1  data_i/color_i valid.
ready_o  out  1  block can accept a byte.
req_o  out  1  bus request.
write_enable_o  out  1  bus write; always equal to req_o.
mem_be_o  out  4  byte enables.
addr_o  out  32  byte address.
write_data_o  out  32  write data.
cursor_row_o  out  5  current row, 0..ROWS-1.
cursor_col_o  out  7  current column, 0..COLS-1.

Behaviour:
- Reset values: state IDLE; cursor 0,0; req_o=0; write_enable_o=0; mem_be_o=0; addr_o=0; write_data_o=0.
- ready_o=0 while rst_i=1; otherwise ready_o=1 exactly when state is IDLE.
- Bus outputs are combinational from state and registers. In IDLE they are all 0.
- A byte is accepted on a clock edge where valid_i&&ready_o. data_i and color_i are latched on that edge.
- Linear index: idx = row*COLS+col. Character write address is CHAR_BASE+idx; colour write address is COL_BASE+idx.
- Byte writes: mem_be_o = 4'b0001<<idx[1:0]; write_data_o = the byte replicated four times.
- States: IDLE, WR_CHAR, WR_COL, CLR_ROW, CLR_ALL.
- Printable byte (0x20..0x7E):
  - WR_CHAR writes the character, then WR_COL writes the attribute.
  - Then col increments.
  - If the old col was COLS-1: col=0, row increments (ROWS-1 wraps to 0), then CLR_ROW. Otherwise return to IDLE.
  - Latency: accept on edge N; bus writes in cycles N+1 and N+2; ready_o high in cycle N+3 when no wrap occurs.
- 0x0A (LF): col=0, row increments with wrap, then CLR_ROW.
- 0x0D (CR): col=0, no bus cycle; stays IDLE, so the next byte can be accepted on the next edge.
- 0x08 (BS):
  - If col>0: col decrements, then WR_CHAR writes 0x20 at the new position, then IDLE. The colour map is untouched.
  - If col==0: no-op.
- 0x0C (FF): CLR_ALL, then cursor 0,0.
- Any other byte: discarded, no bus cycle.
- CLR_ROW:
  - COLS/4 consecutive word writes to the character map: mem_be_o=4'hF, write_data_o=32'h2020_2020.
  - Address starts at CHAR_BASE+row*COLS and steps by 4.
  - Word counter wraps from 19 to 0, then IDLE. The cursor is unchanged during the clear.
- CLR_ALL: same as CLR_ROW but ROWS*COLS/4 words (600), starting at CHAR_BASE; the last address is 0x95C.
- Wrap from row ROWS-1 to 0 clears row 0. There is no scrolling.
- Reset asserted mid-operation: the operation is abandoned. The next cycle shows reset values; partial clears are not resumed.
- Width rules: row*COLS is computed at 12 bits (max 2399 fits). The address is zero-extended to 32 bits.

Decomposition:
- Package vga_console_pkg holds:
  - the state enum;
  - COLS, ROWS and WORDS_PER_ROW constants;
  - CHAR_BASE and COL_BASE;
  - control-code localparams LF, CR, BS, FF;
  - the SPACE_WORD constant.
- One sub-module, vga_cursor, handles the row/col registers, increment/decrement/wrap logic and idx computation.

Test Plan:
- Reset, then send 0x41 with color 0x1F:
  - cycle N+1: addr 0x0, be 4'b0001, wdata 0x41414141;
  - cycle N+2: addr 0x1000, be 4'b0001, wdata 0x1F1F1F1F;
  - after that: col=1.
- Send 80 printable bytes: the last char goes to 0x4F with be 4'b1000. This is followed by 20 writes at 0x50..0x9C with be 4'hF and wdata 0x20202020. The cursor ends at 1,0.
- Cursor 29,5, send 0x0A: 20 writes at 0x000..0x04C, cursor 0,0. Then CR at col 0 causes no req_o.
- Cursor 0,3, send 0x08: a single write at addr 0x2, be 4'b0100, wdata 0x20202020; cursor 0,2. BS at col 0 causes no bus activity.
- Send 0x0C: exactly 600 writes at 0x000..0x95C, ready_o=0 throughout, cursor 0,0. Assert rst_i at write 300: req_o=0 on the next cycle and ready_o=1 the cycle after reset is released.
- Send 0x07 with valid_i held: accepted in one cycle, no req_o, cursor unchanged, ready_o stays high.
